// File: rtl/regfile_mp_if.sv
// ----------------------------------------------------------------------------
// regfile_mp_if: write/read bus of the multi-port register file.
//   we     : write enable
//   waddr  : write address (AW bits)
//   wdata  : write data (WIDTH bits)
//   raddr  : packed read addresses, port k at [k*AW +: AW]
//   rdata  : packed read data, port k at [k*WIDTH +: WIDTH]
// master drives the addresses/data; slave (the register file) returns rdata.
// ----------------------------------------------------------------------------
interface regfile_mp_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 32,
    parameter int unsigned NREAD = 2
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic                   we;
    logic [AW-1:0]          waddr;
    logic [WIDTH-1:0]       wdata;
    logic [NREAD*AW-1:0]    raddr;
    logic [NREAD*WIDTH-1:0] rdata;

    modport master (output we, waddr, wdata, raddr, input rdata);
    modport slave  (input we, waddr, wdata, raddr, output rdata);
endinterface

// File: rtl/regfile_mp.sv
// ----------------------------------------------------------------------------
// regfile_mp: parametrised register file, one synchronous write port and
// NREAD independent combinational read ports.
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset, clears every register
//   bus      : regfile_mp_if.slave (we/waddr/wdata in, raddr in, rdata out)
// Options: ZERO_REG hardwires register 0 to zero; BYPASS forwards wdata to a
// read port addressing the register being written in the same cycle.
// ----------------------------------------------------------------------------
module regfile_mp #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned NREAD    = 2,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b0
) (
    input  logic         clk,
    input  logic         reset_n,
    regfile_mp_if.slave  bus
);
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned NPAD = 1 << AW;       // leaves of the read tree
    localparam int unsigned N4   = AW / 2;        // number of 4:1 stages
    localparam bit          ODD  = (AW % 2) == 1; // trailing 2:1 stage needed
    localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];

    logic [WIDTH-1:0] regs [DEPTH];
    logic             wr_ok_c;

    // A write is honoured only for an existing, writable register.
    assign wr_ok_c = bus.we
                   && ({1'b0, bus.waddr} < DEPTH_W)
                   && !(ZERO_REG && (bus.waddr == '0));

    // Storage: async clear, single write port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok_c) begin
            regs[bus.waddr] <= bus.wdata;
        end
    end

    // Per-port read: balanced 4:1 tree on address pairs (LSBs first), final
    // 2:1 on the top bit when AW is odd. Padded leaves read 0, which also
    // covers out-of-range addresses without extra compare logic.
    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [AW-1:0]    ra;
        logic [WIDTH-1:0] rd_c;

        assign ra = bus.raddr[k*AW +: AW];

        always_comb begin
            logic [WIDTH-1:0] node [NPAD];
            for (int i = 0; i < int'(NPAD); i++) begin
                node[i] = '0;
            end
            for (int i = 0; i < int'(DEPTH); i++) begin
                node[i] = regs[i];
            end
            if (ZERO_REG) begin
                node[0] = '0;
            end
            // In-place reduction: node i reads 4i..4i+3, all >= i, so
            // nothing not yet consumed is overwritten.
            for (int s = 0; s < int'(N4); s++) begin
                for (int i = 0; i < int'(NPAD >> (2 * (s + 1))); i++) begin
                    node[i] = node[4 * i + int'(ra[2 * s +: 2])];
                end
            end
            if (ODD) begin
                node[0] = ra[AW-1] ? node[1] : node[0];
            end
            rd_c = node[0];
            if (BYPASS && wr_ok_c && (ra == bus.waddr)) begin
                rd_c = bus.wdata;
            end
        end

        assign bus.rdata[k*WIDTH +: WIDTH] = rd_c;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file for the MIPS data path, replacing fixed 32:1 single-bit read muxing with WIDTH-bit, DEPTH-entry storage and NREAD independent combinational read ports.
- Single synchronous write port; optional hardwired-zero register 0; optional same-cycle write-to-read bypass.
- Sits between decode (read addresses rs/rt) and writeback (write address rd/rt).

Parameters:
- WIDTH, 32, bits per register.
- DEPTH, 32, number of registers; any value >= 2, need not be a power of two.
- NREAD, 2, number of read ports (>= 1).
- ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes.
- BYPASS, 0, 1 = a read of the address being written this cycle returns wdata combinationally.
- Derived AW = $clog2(DEPTH); not overridable.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- we  in  1  write enable.
- waddr  in  AW  write address.
- wdata  in  WIDTH  write data.
- raddr  in  NREAD*AW  packed read addresses; port k uses bits [k*AW +: AW].
- rdata  out  NREAD*WIDTH  packed read data; port k uses bits [k*WIDTH +: WIDTH].

Behaviour:
- One clock. Reset is asynchronous and active-low: reset_n low immediately clears every register to 0, independent of clk.
- With reset_n low, every rdata word reads 0, and any read port with BYPASS=1 returns wdata only if the bypass conditions hold.
- Write: at a rising clk edge, if reset_n=1, we=1 and waddr < DEPTH, reg[waddr] <= wdata.
  - Ignored if ZERO_REG=1 and waddr=0.
  - waddr >= DEPTH: write dropped, no aliasing or wrap-around.
- Read: rdata[k] is purely combinational from raddr[k] and array state, so latency is 0 cycles.
  - raddr[k] >= DEPTH reads 0.
  - ZERO_REG=1 and raddr[k]=0 reads 0.
  - Written data becomes visible on the cycle after the write edge.
- Bypass (BYPASS=1): if we=1, raddr[k]=waddr, waddr < DEPTH, and not (ZERO_REG=1 and waddr=0), then rdata[k]=wdata in the same cycle.
- Bypass (BYPASS=0): rdata[k] shows the old register value until the edge.
- All read ports are independent; any number may address the same register.
- Read mux is a balanced tree of 4:1 stages plus a final 2:1 where needed, per port. No priority logic.
- Reset asserted mid-write: reset wins and the register stays 0. The first write after reset_n rises takes effect at the first qualifying edge.
- No X propagation: every path yields a defined value for in-range or out-of-range addresses.

Test Plan:
- Reset: drive reset_n=0 asynchronously mid-cycle after writing 0xDEADBEEF to reg 5 -> raddr0=5 reads 0x00000000 immediately, without waiting for a clk edge.
- Write/read: write 0x12345678 to reg 7 -> raddr0=7 reads 0x12345678 from the next cycle; raddr1=7 on the same cycle also reads 0x12345678.
- Zero register (ZERO_REG=1): write 0xFFFFFFFF to reg 0 -> reads 0; with ZERO_REG=0, the same write reads 0xFFFFFFFF.
- Bypass:
  - BYPASS=1, we=1, waddr=3, wdata=0xA5A5A5A5, raddr0=3 -> rdata0=0xA5A5A5A5 in the same cycle.
  - BYPASS=0 -> old value (0) in the same cycle, 0xA5A5A5A5 next cycle.
- Non-power-of-two (DEPTH=20, AW=5):
  - Write 0x55 to reg 19 -> reads 0x55.
  - Write to 25 -> dropped; raddr=25 reads 0 and reg 9 is unchanged.
- Port independence (NREAD=4, WIDTH=8): load reg i = i*3 for all i, then sweep all ports with distinct random addresses for 1000 cycles -> every rdata[k] matches the reference-model array.
